// File: rtl/odbiornik_pkg.sv
// Shared constants for the UART receiver: state codes and default bit timing.
package odbiornik_pkg;

    // Default timing: 100 MHz system clock, 9600 baud.
    localparam int unsigned CLKS_PER_BIT_DEF = 10417;

    // State codes, kept identical to the transmitter's encoding.
    localparam logic [2:0] SPOCZYNEK   = 3'b000;
    localparam logic [2:0] START       = 3'b001;
    localparam logic [2:0] DATA        = 3'b010;
    localparam logic [2:0] STOP        = 3'b011;
    localparam logic [2:0] CZYSZCZENIE = 3'b100;

    // Bit-period counter width: enough to hold n-1, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/odbiornik_if.sv
// Serial line in, received byte and status pulses out.
interface odbiornik_if;

    logic       RXD_i;
    logic [7:0] rxDATA;
    logic       RX_DONE;
    logic       RX_ERR;
    logic       RX_BUSY;

    // Side that drives the line and consumes the received data.
    modport master (
        output RXD_i,
        input  rxDATA,
        input  RX_DONE,
        input  RX_ERR,
        input  RX_BUSY
    );

    // The receiver itself.
    modport slave (
        input  RXD_i,
        output rxDATA,
        output RX_DONE,
        output RX_ERR,
        output RX_BUSY
    );

endinterface

// File: rtl/odbiornik_sync_2ff.sv
// Two-flop synchronizer for the asynchronous serial line; resets to idle (1).
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values: shift the raw input through two stages.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronizer flops, idle-high after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/odbiornik.sv
// UART receiver, 8N1, LSB first, mid-bit sampling on the synchronized line.
module odbiornik
    import odbiornik_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    odbiornik_if.slave  rx
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TICK = CW'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);

    logic          rxs;
    logic [2:0]    state_q,       state_d;
    logic [CW-1:0] licznik_q,     licznik_d;
    logic [2:0]    licznik_bit_q, licznik_bit_d;
    logic [7:0]    shift_q,       shift_d;
    logic [7:0]    data_q,        data_d;
    logic          done_q,        done_d;
    logic          err_q,         err_d;
    logic          busy_q,        busy_d;

    sync_2ff u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (rx.RXD_i),
        .q_o   (rxs)
    );

    // Next-state, counters, shift register and output pulses.
    always_comb begin
        state_d       = state_q;
        licznik_d     = licznik_q;
        licznik_bit_d = licznik_bit_q;
        shift_d       = shift_q;
        data_d        = data_q;
        done_d        = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            SPOCZYNEK: begin
                if (!rxs) begin
                    licznik_d     = '0;
                    licznik_bit_d = '0;
                    state_d       = START;
                end
            end
            START: begin
                if (licznik_q == HALF_TICK) begin
                    licznik_d = '0;
                    // A line back high at mid start bit was only a glitch.
                    state_d   = rxs ? SPOCZYNEK : DATA;
                end else begin
                    licznik_d = licznik_q + CW'(1);
                end
            end
            DATA: begin
                if (licznik_q == LAST_TICK) begin
                    licznik_d               = '0;
                    shift_d[licznik_bit_q] = rxs;
                    if (licznik_bit_q == 3'd7) begin
                        licznik_bit_d = '0;
                        state_d       = STOP;
                    end else begin
                        licznik_bit_d = licznik_bit_q + 3'd1;
                    end
                end else begin
                    licznik_d = licznik_q + CW'(1);
                end
            end
            STOP: begin
                if (licznik_q == LAST_TICK) begin
                    licznik_d = '0;
                    if (rxs) begin
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = SPOCZYNEK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = CZYSZCZENIE;
                    end
                end else begin
                    licznik_d = licznik_q + CW'(1);
                end
            end
            CZYSZCZENIE: begin
                // Hold here through a break so it cannot retrigger.
                if (rxs) begin
                    state_d = SPOCZYNEK;
                end
            end
            default: begin
                state_d = SPOCZYNEK;
            end
        endcase

        busy_d = (state_d != SPOCZYNEK);
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= SPOCZYNEK;
            licznik_q     <= '0;
            licznik_bit_q <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            licznik_q     <= licznik_d;
            licznik_bit_q <= licznik_bit_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            done_q        <= done_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
        end
    end

    assign rx.rxDATA  = data_q;
    assign rx.RX_DONE = done_q;
    assign rx.RX_ERR  = err_q;
    assign rx.RX_BUSY = busy_q;

endmodule

// File: tb/tb_odbiornik.sv
// Bench for the UART receiver: frame table plus hand-written corner sequences.
module tb_odbiornik;

    localparam int unsigned CLKS = 16;

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } ev_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   start_cyc = 0;
    int   last_pulse_cyc = 0;
    ev_t  exp_q[$];
    vec_t vecs[7];

    odbiornik_if rx_if();

    odbiornik #(.CLKS_PER_BIT(CLKS)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx    (rx_if.slave)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bit period on the line; entered and left at posedge + 1.
    task automatic drive_bit(input logic b);
        rx_if.RXD_i = b;
        repeat (CLKS) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_ok);
        rx_if.RXD_i = 1'b1;
    endtask

    task automatic push_ev(input logic is_err, input logic [7:0] d);
        ev_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    task automatic chk_settled(input string name, input logic [7:0] exp_data);
        chk({name, "_pulse_seen"}, exp_q.size(), 0);
        chk({name, "_rxdata"}, 32'(rx_if.rxDATA), 32'(exp_data));
        chk({name, "_busy"}, 32'(rx_if.RX_BUSY), 0);
    endtask

    initial begin
        rx_if.RXD_i = 1'b1;

        // Scoreboard: every pulse must match the oldest expected event.
        fork
            forever begin
                @(negedge clk_i);
                if (!rst_i && (rx_if.RX_DONE || rx_if.RX_ERR)) begin
                    last_pulse_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: done=%0b err=%0b data=0x%0h, expected none (cycle %0d)",
                                 rx_if.RX_DONE, rx_if.RX_ERR, rx_if.rxDATA, cyc);
                    end else begin
                        ev_t e;
                        e = exp_q.pop_front();
                        chk("pulse_kind", 32'({rx_if.RX_DONE, rx_if.RX_ERR}),
                            e.is_err ? 32'd1 : 32'd2);
                        if (!e.is_err) chk("pulse_data", 32'(rx_if.rxDATA), 32'(e.data));
                    end
                end
            end
        join_none

        vecs[0] = '{8'h41, 1'b1, 8'h41};
        vecs[1] = '{8'h5A, 1'b0, 8'h41};
        vecs[2] = '{8'h00, 1'b1, 8'h00};
        vecs[3] = '{8'hFF, 1'b1, 8'hFF};
        vecs[4] = '{8'h80, 1'b1, 8'h80};
        vecs[5] = '{8'h01, 1'b0, 8'h80};
        vecs[6] = '{8'hC3, 1'b1, 8'hC3};

        // Reset values.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_rxdata", 32'(rx_if.rxDATA), 0);
        chk("reset_done",   32'(rx_if.RX_DONE), 0);
        chk("reset_err",    32'(rx_if.RX_ERR), 0);
        chk("reset_busy",   32'(rx_if.RX_BUSY), 0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Table of single frames, each followed by one idle bit.
        for (int i = 0; i < 7; i++) begin
            push_ev(!vecs[i].stop_ok, vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop_ok);
            if (i == 0) chk("first_done_latency", last_pulse_cyc - start_cyc, 155);
            drive_bit(1'b1);
            chk_settled("vec", vecs[i].exp_data);
        end

        // Three-cycle glitch on an idle line.
        begin
            int g0;
            g0 = cyc;
            rx_if.RXD_i = 1'b0;
            repeat (3) @(posedge clk_i);
            #1;
            rx_if.RXD_i = 1'b1;
            while (cyc < g0 + 5) @(negedge clk_i);
            chk("glitch_busy_high", 32'(rx_if.RX_BUSY), 1);
            while (cyc < g0 + 12) @(negedge clk_i);
            chk("glitch_busy_low", 32'(rx_if.RX_BUSY), 0);
            @(posedge clk_i);
            #1;
            drive_bit(1'b1);
            drive_bit(1'b1);
            chk_settled("glitch", 8'hC3);
        end

        // Back-to-back frames with no idle gap.
        push_ev(1'b0, 8'h55);
        push_ev(1'b0, 8'hAA);
        send_frame(8'h55, 1'b1);
        send_frame(8'hAA, 1'b1);
        drive_bit(1'b1);
        chk_settled("b2b", 8'hAA);

        // Reset in the middle of data bit 3, then a clean frame.
        begin
            logic [7:0] d;
            d = 8'h7E;
            drive_bit(1'b0);
            for (int i = 0; i < 3; i++) drive_bit(d[i]);
            rx_if.RXD_i = d[3];
            repeat (8) @(posedge clk_i);
            #1;
            chk("pre_reset_busy", 32'(rx_if.RX_BUSY), 1);
            rst_i = 1'b1;
            @(negedge clk_i);
            chk("midreset_rxdata", 32'(rx_if.rxDATA), 0);
            chk("midreset_done",   32'(rx_if.RX_DONE), 0);
            chk("midreset_err",    32'(rx_if.RX_ERR), 0);
            chk("midreset_busy",   32'(rx_if.RX_BUSY), 0);
            rx_if.RXD_i = 1'b1;
            @(posedge clk_i);
            #1;
            rst_i = 1'b0;
            drive_bit(1'b1);
            drive_bit(1'b1);
            drive_bit(1'b1);
            chk_settled("post_reset_idle", 8'h00);
            push_ev(1'b0, d);
            send_frame(d, 1'b1);
            drive_bit(1'b1);
            chk_settled("post_reset_frame", 8'h7E);
        end

        // Line held low for 30 bit times: exactly one framing error.
        push_ev(1'b1, 8'h00);
        rx_if.RXD_i = 1'b0;
        repeat (30 * CLKS) @(posedge clk_i);
        #1;
        chk("break_busy", 32'(rx_if.RX_BUSY), 1);
        rx_if.RXD_i = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        chk_settled("break", 8'h7E);
        push_ev(1'b0, 8'h33);
        send_frame(8'h33, 1'b1);
        drive_bit(1'b1);
        chk_settled("after_break", 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/odbiornik.md
ODBIORNIK -- requirements
Module: odbiornik

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, meaning clock cycles per UART bit (100 MHz / 9600 baud).
REQ-002 The block SHALL have port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port RXD_i  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 The block SHALL have port rxDATA  output  8  last correctly framed received byte.
REQ-006 The block SHALL have port RX_DONE  output  1  one-cycle pulse when rxDATA is updated; drives the downstream transmitter start.
REQ-007 The block SHALL have port RX_ERR  output  1  one-cycle pulse on framing error (stop bit sampled low).
REQ-008 The block SHALL have port RX_BUSY  output  1  high whenever the state is not SPOCZYNEK.

Function
REQ-009 RXD_i SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rxs.
REQ-010 The state machine SHALL have states SPOCZYNEK, START, DATA, STOP, CZYSZCZENIE, with bit counter licznik and bit index licznikBIT (0..7).
REQ-011 In SPOCZYNEK, when rxs is 0, the block SHALL clear licznik and enter START; call this cycle t0.
REQ-012 In START, at t0+HALF, where HALF = CLKS_PER_BIT/2 (integer division), it SHALL sample rxs: 0 -> DATA with licznik cleared; 1 -> SPOCZYNEK (glitch rejected, no pulse).
REQ-013 In DATA, bit k (k=0..7) SHALL be sampled at t0+HALF+(k+1)*CLKS_PER_BIT into shift position k; after k=7 it SHALL go to STOP.
REQ-014 In STOP, the stop bit SHALL be sampled at t0+HALF+9*CLKS_PER_BIT; the result SHALL be visible on the following cycle.
REQ-015 On stop sample 1: rxDATA SHALL load the shifted byte, and RX_DONE SHALL be high for exactly one cycle, the same cycle rxDATA changes.
REQ-016 On stop sample 0: RX_ERR SHALL pulse for one cycle, rxDATA SHALL hold its previous value, and RX_DONE SHALL stay low.
REQ-017 CZYSZCZENIE SHALL wait until rxs is 1, then return to SPOCZYNEK, so a held-low line (break) produces exactly one RX_ERR and no retrigger.
REQ-018 A new start bit arriving in the cycle after return to SPOCZYNEK SHALL be accepted (back-to-back frames with no idle gap beyond the stop bit).
REQ-019 rxDATA SHALL hold its value indefinitely between frames, and RX_DONE and RX_ERR SHALL never be high together.
REQ-020 licznik SHALL be wide enough for CLKS_PER_BIT-1 and SHALL not wrap within a bit period.

Reset
REQ-021 While rst_i is high, state SHALL be SPOCZYNEK, licznik=0, licznikBIT=0, shift register=0, rxDATA=8'h00, RX_DONE=0, RX_ERR=0, RX_BUSY=0, and synchronizer flops=1 (idle).
REQ-022 Reset asserted mid-frame SHALL abort the frame with no pulse; after release, the block SHALL wait for a new falling edge.

Structure
REQ-023 Package odbiornik_pkg SHALL hold the state encodings (3-bit, matching the transmitter: SPOCZYNEK=000, START=001, DATA=010, STOP=011, CZYSZCZENIE=100) and the default CLKS_PER_BIT.
REQ-024 The synchronizer SHALL be the single sub-module sync_2ff (reset value 1).

Verification (run with CLKS_PER_BIT=16)
REQ-025 A frame carrying 0x41 with a valid stop bit SHALL produce rxDATA=0x41 and one RX_DONE pulse at t0+8+144+1 relative to synchronized start detection.
REQ-026 A 3-cycle low glitch on idle RXD_i SHALL produce no RX_DONE or RX_ERR and SHALL return RX_BUSY to 0 by t0+9.
REQ-027 A frame carrying 0x5A with stop bit 0 SHALL produce one RX_ERR pulse, leave rxDATA at its prior value (0x41), and produce no RX_DONE.
REQ-028 Back-to-back frames 0x55 then 0xAA with no gap SHALL produce two RX_DONE pulses with rxDATA 0x55 then 0xAA.
REQ-029 rst_i pulsed during data bit 3 SHALL force all outputs to their reset values; the next frame 0x7E SHALL then be received correctly.
REQ-030 RXD_i held low for 30 bit times SHALL produce exactly one RX_ERR; a frame 0x33 after the line returns high SHALL be received correctly.
